// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions used by the state controller, the message
// scheduler and the round datapath.
//   - controller state encodings driven on the `state` bus
//   - block / round sizing constants
//   - scheduler FSM encoding
//   - rotl1: rotate a 32-bit word left by one bit
package sha1_pkg;

    localparam logic [1:0] ST_RESET   = 2'b00;
    localparam logic [1:0] ST_INIT    = 2'b01;
    localparam logic [1:0] ST_COMPUTE = 2'b10;
    // Encoding 2'b11 is unused by the controller and means "hold".
    localparam logic [1:0] ST_HOLD    = 2'b11;

    localparam int BLOCK_WORDS = 16;
    localparam int ROUNDS      = 80;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'b00,
        SCHED_FULL = 2'b01,
        SCHED_RUN  = 2'b10,
        SCHED_DONE = 2'b11
    } sched_fsm_e;

    // Rotate left by one: bit 31 wraps around to bit 0.
    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

endpackage

// File: rtl/sha1_w_ring.sv
// 16-entry circular buffer holding the sliding window of schedule words.
// Ports:
//   clk        rising-edge clock
//   we_i       write enable
//   waddr_i    write slot
//   wdata_i    write data
//   raddrN_i   four independent read slots
//   rdataN_o   combinational read data for each read slot
// Contents are not reset: every slot is written during a block load
// before any of it is read.
module sha1_w_ring
    import sha1_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [3:0]        raddr0_i,
    input  logic [3:0]        raddr1_i,
    input  logic [3:0]        raddr2_i,
    input  logic [3:0]        raddr3_i,
    output logic [WORD_W-1:0] rdata0_o,
    output logic [WORD_W-1:0] rdata1_o,
    output logic [WORD_W-1:0] rdata2_o,
    output logic [WORD_W-1:0] rdata3_o
);

    logic [WORD_W-1:0] mem_q [BLOCK_WORDS];

    // Single write port into the ring.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
    assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/sha1_message_scheduler.sv
// SHA-1 message scheduler. Loads a 512-bit block as sixteen 32-bit words
// while the controller is in its initialize state, then emits W0..W79 one
// per handshake while in compute, recomputing each word in place in a
// 16-entry ring.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   state               controller state (00 reset/abort, 01 init, 10 compute, 11 hold)
//   word_valid/word_in  load word handshake input, word 0 first
//   word_ready          load word accepted this cycle
//   w_valid/w_ready     schedule word handshake towards the round datapath
//   w_out               W[round], 0 when w_valid is low
//   round               index of the presented word
//   w_last              presented word is W79
//   block_done          one-cycle pulse after W79 is consumed
module sha1_message_scheduler
    import sha1_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        state,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    output logic              word_ready,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [6:0]        round,
    output logic              w_last,
    output logic              block_done
);

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
    localparam logic [6:0] FIRST_DERIVED_T = 7'(BLOCK_WORDS);

    sched_fsm_e        fsm_q;
    logic [3:0]        lcnt_q;
    logic [6:0]        t_q;

    logic              run_s;
    logic              load_fire_s;
    logic              run_fire_s;
    logic              ring_we_s;
    logic [3:0]        ring_waddr_s;
    logic [WORD_W-1:0] ring_wdata_s;
    logic [WORD_W-1:0] tap3_s;
    logic [WORD_W-1:0] tap8_s;
    logic [WORD_W-1:0] tap14_s;
    logic [WORD_W-1:0] tap16_s;
    logic [WORD_W-1:0] w_calc_s;

    assign run_s       = (fsm_q == SCHED_RUN);
    assign word_ready  = !reset && (fsm_q == SCHED_IDLE) && (state == ST_INIT);
    // A hold state on the controller bus suspends emission without
    // leaving RUN.
    assign w_valid     = run_s && (state != ST_HOLD);
    assign load_fire_s = word_valid && word_ready;
    // An abort in the same cycle as a handshake wins: the word is not consumed.
    assign run_fire_s  = w_valid && w_ready && !reset && (state != ST_RESET);

    assign round      = run_s ? t_q : 7'd0;
    assign w_last     = w_valid && (t_q == LAST_T);
    assign block_done = (fsm_q == SCHED_DONE);

    // Taps for W[t]: slot (t & 15) still holds W[t-16] until it is overwritten.
    sha1_w_ring #(.WORD_W(WORD_W)) u_ring (
        .clk      (clk),
        .we_i     (ring_we_s),
        .waddr_i  (ring_waddr_s),
        .wdata_i  (ring_wdata_s),
        .raddr0_i (t_q[3:0] - 4'd3),
        .raddr1_i (t_q[3:0] - 4'd8),
        .raddr2_i (t_q[3:0] - 4'd14),
        .raddr3_i (t_q[3:0]),
        .rdata0_o (tap3_s),
        .rdata1_o (tap8_s),
        .rdata2_o (tap14_s),
        .rdata3_o (tap16_s)
    );

    // Schedule word selection: loaded words first, then the XOR/rotate recurrence.
    always_comb begin
        w_calc_s = tap16_s;
        if (t_q >= FIRST_DERIVED_T) begin
            w_calc_s = rotl1(tap3_s ^ tap8_s ^ tap14_s ^ tap16_s);
        end else begin
            w_calc_s = tap16_s;
        end
    end

    assign w_out = w_valid ? w_calc_s : {WORD_W{1'b0}};

    // Ring write: load words during IDLE, derived words written back during RUN.
    always_comb begin
        ring_we_s    = 1'b0;
        ring_waddr_s = lcnt_q;
        ring_wdata_s = word_in;
        if (run_s) begin
            ring_we_s    = run_fire_s && (t_q >= FIRST_DERIVED_T);
            ring_waddr_s = t_q[3:0];
            ring_wdata_s = w_calc_s;
        end else begin
            ring_we_s    = load_fire_s;
            ring_waddr_s = lcnt_q;
            ring_wdata_s = word_in;
        end
    end

    // Scheduler FSM with load and round counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= SCHED_IDLE;
            lcnt_q <= 4'd0;
            t_q    <= 7'd0;
        end else if (state == ST_RESET) begin
            fsm_q  <= SCHED_IDLE;
            lcnt_q <= 4'd0;
            t_q    <= 7'd0;
        end else begin
            case (fsm_q)
                SCHED_IDLE: begin
                    if (load_fire_s) begin
                        // Wraps to 0 on the sixteenth word.
                        lcnt_q <= lcnt_q + 4'd1;
                        if (lcnt_q == 4'd15) begin
                            fsm_q <= SCHED_FULL;
                        end
                    end
                end
                SCHED_FULL: begin
                    if (state == ST_COMPUTE) begin
                        fsm_q <= SCHED_RUN;
                        t_q   <= 7'd0;
                    end
                end
                SCHED_RUN: begin
                    if (run_fire_s) begin
                        if (t_q == LAST_T) begin
                            fsm_q <= SCHED_DONE;
                        end else begin
                            t_q <= t_q + 7'd1;
                        end
                    end
                end
                SCHED_DONE: begin
                    fsm_q <= SCHED_IDLE;
                    t_q   <= 7'd0;
                end
                default: begin
                    fsm_q  <= SCHED_IDLE;
                    lcnt_q <= 4'd0;
                    t_q    <= 7'd0;
                end
            endcase
        end
    end

endmodule
